rf_write_arbiter: RTL and testbench

- Shares the single register-file write port (writeEn/dest/writeVal) between two producers.
- Requester 0 is the pipeline write-back stage, with fixed priority. Requester 1 is a multi-cycle unit (mul/div or load return), protected by an anti-starvation counter.
- The output stage is registered on posedge clk so dest/writeVal are stable when the register file samples them on negedge clk.

---
 rtl/rf_write_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port between two producers:
//   requester 0 : pipeline write-back stage, fixed priority
//   requester 1 : multi-cycle unit (mul/div, load return), protected from
//                 starvation by a saturating wait counter that eventually
//                 forces a grant in its favour
//
// The write port (writeEn/dest/writeVal) is registered on posedge clk, so it
// is stable when the register file samples it on negedge clk. A transfer
// seen at posedge N shows up on the write port during the cycle after N.
//
// Parameters:
//   WORD_LEN           data width of writeVal
//   REG_FILE_ADDR_LEN  width of a register address
//   MAX_WAIT           consecutive refused cycles before requester 1 is
//                      forced through (legal range 1..15)
//
// Ports:
//   clk, rst           clock (posedge) and asynchronous active-high reset
//   req0_valid/dest/val  write-back request (held until accepted)
//   req0_ready         req0 accepted this cycle (combinational)
//   req1_valid/dest/val  multi-cycle unit request (held until accepted)
//   req1_ready         req1 accepted this cycle (combinational)
//   writeEn            register-file write enable (registered)
//   dest               register-file write address (registered)
//   writeVal           register-file write data (registered)
//   force1             starvation override active (registered)
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int WORD_LEN          = 32,
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int MAX_WAIT          = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         req0_valid,
    input  logic [REG_FILE_ADDR_LEN-1:0] req0_dest,
    input  logic [WORD_LEN-1:0]          req0_val,
    output logic                         req0_ready,

    input  logic                         req1_valid,
    input  logic [REG_FILE_ADDR_LEN-1:0] req1_dest,
    input  logic [WORD_LEN-1:0]          req1_val,
    output logic                         req1_ready,

    output logic                         writeEn,
    output logic [REG_FILE_ADDR_LEN-1:0] dest,
    output logic [WORD_LEN-1:0]          writeVal,
    output logic                         force1
);

    // Arbitration states:
    //   ST_IDLE  : no pressure on requester 1, wait counter is zero
    //   ST_WAIT  : requester 1 is being refused, counter is running
    //   ST_FORCE : requester 1 owns the port for exactly one cycle
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [1:0]                   state_q,    state_d;
    logic [3:0]                   waitCnt_q,  waitCnt_d;
    logic                         writeEn_q,  writeEn_d;
    logic [REG_FILE_ADDR_LEN-1:0] dest_q,     dest_d;
    logic [WORD_LEN-1:0]          writeVal_q, writeVal_d;

    logic       forceActive;
    logic       xfer0;
    logic       xfer1;
    logic       req1Blocked;
    logic [3:0] waitCntInc;

    // force1 is a pure decode of the state register, so it is glitch-free
    // and changes only on posedge clk or on reset.
    assign forceActive = (state_q == ST_FORCE);
    assign force1      = forceActive;

    // Ready rules. Requester 0 wins whenever it is valid, except while the
    // starvation override is active. The two readies are never both granted
    // with both valids, so at most one transfer happens per cycle.
    assign req0_ready = ~forceActive;
    assign req1_ready = forceActive | ~req0_valid;

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    // Requester 1 counts as starving only when it was refused by normal
    // priority; the forced cycle itself never counts.
    assign req1Blocked = req1_valid & ~req1_ready & ~forceActive;

    // Saturating increment of the wait counter.
    assign waitCntInc = (waitCnt_q >= MaxWait) ? MaxWait : (waitCnt_q + 4'd1);

    // Next-state logic for the starvation FSM and its counter. The move into
    // ST_FORCE happens on the same edge at which the counter reaches
    // MAX_WAIT, so requester 1 is refused for exactly MAX_WAIT cycles before
    // it is granted. Withdrawing req1_valid at any point returns to ST_IDLE.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            ST_IDLE: begin
                waitCnt_d = 4'd0;
                if (req1Blocked) begin
                    waitCnt_d = waitCntInc;
                    state_d   = (waitCntInc == MaxWait) ? ST_FORCE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req1_valid || xfer1) begin
                    state_d   = ST_IDLE;
                    waitCnt_d = 4'd0;
                end else if (req1Blocked) begin
                    waitCnt_d = waitCntInc;
                    if (waitCntInc == MaxWait) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (!req1_valid || xfer1) begin
                    state_d   = ST_IDLE;
                    waitCnt_d = 4'd0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                waitCnt_d = 4'd0;
            end
        endcase
    end

    // Next-state logic for the registered write port. Address and data
    // follow whichever requester transferred; without a transfer they keep
    // their old values so the register file sees a quiet bus. A transfer
    // aimed at register 0 still updates the bus but never raises writeEn,
    // because register 0 is hard-wired to zero.
    always_comb begin
        writeEn_d  = 1'b0;
        dest_d     = dest_q;
        writeVal_d = writeVal_q;
        if (xfer1) begin
            writeEn_d  = |req1_dest;
            dest_d     = req1_dest;
            writeVal_d = req1_val;
        end else if (xfer0) begin
            writeEn_d  = |req0_dest;
            dest_d     = req0_dest;
            writeVal_d = req0_val;
        end
    end

    // State registers. Reset is asynchronous so that a write already
    // presented on the port is withdrawn immediately, without waiting for a
    // clock edge; the arbiter restarts from ST_IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= 4'd0;
            writeEn_q  <= 1'b0;
            dest_q     <= '0;
            writeVal_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            writeEn_q  <= writeEn_d;
            dest_q     <= dest_d;
            writeVal_q <= writeVal_d;
        end
    end

    assign writeEn  = writeEn_q;
    assign dest     = dest_q;
    assign writeVal = writeVal_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed bench for rf_write_arbiter (default parameters, MAX_WAIT = 4).
// Each vector gives the requester inputs for one cycle, the readies expected
// before the edge, and the write port / force1 expected after the edge.
// Hand-written sequences cover withdrawal during the forced cycle and an
// asynchronous reset while a write and the override are both active.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    typedef struct {
        logic        r0v;
        logic [4:0]  r0d;
        logic [31:0] r0x;
        logic        r1v;
        logic [4:0]  r1d;
        logic [31:0] r1x;
        logic        eR0Rdy;
        logic        eR1Rdy;
        logic        eWe;
        logic [4:0]  eDest;
        logic [31:0] eVal;
        logic        eForce;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_dest;
    logic [31:0] req0_val;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_dest;
    logic [31:0] req1_val;
    logic        req1_ready;
    logic        writeEn;
    logic [4:0]  dest;
    logic [31:0] writeVal;
    logic        force1;

    int nChecks = 0;
    int nFails  = 0;
    string curTag = "reset";

    logic [31:0] regModel [32];

    vec_t vecs[$];

    rf_write_arbiter #(
        .WORD_LEN(32),
        .REG_FILE_ADDR_LEN(5),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_dest(req0_dest),
        .req0_val(req0_val),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_dest(req1_dest),
        .req1_val(req1_val),
        .req1_ready(req1_ready),
        .writeEn(writeEn),
        .dest(dest),
        .writeVal(writeVal),
        .force1(force1)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: samples the write port on negedge, like the
    // real register file does.
    always @(negedge clk) begin
        if (writeEn) regModel[dest] <= writeVal;
    end

    function automatic vec_t mk(
        input logic r0v, input logic [4:0] r0d, input logic [31:0] r0x,
        input logic r1v, input logic [4:0] r1d, input logic [31:0] r1x,
        input logic eR0Rdy, input logic eR1Rdy,
        input logic eWe, input logic [4:0] eDest, input logic [31:0] eVal,
        input logic eForce);
        vec_t v;
        v.r0v = r0v;  v.r0d = r0d;  v.r0x = r0x;
        v.r1v = r1v;  v.r1d = r1d;  v.r1x = r1x;
        v.eR0Rdy = eR0Rdy;  v.eR1Rdy = eR1Rdy;
        v.eWe = eWe;  v.eDest = eDest;  v.eVal = eVal;  v.eForce = eForce;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h",
                     curTag, name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req0_valid = v.r0v;
        req0_dest  = v.r0d;
        req0_val   = v.r0x;
        req1_valid = v.r1v;
        req1_dest  = v.r1d;
        req1_val   = v.r1x;
    endtask

    // One cycle: drive, check readies before the edge, check the registered
    // outputs just after the edge.
    task automatic step(input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, v.eR0Rdy});
        checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, v.eR1Rdy});
        @(posedge clk);
        #1;
        checkOutput("writeEn",  {31'd0, writeEn}, {31'd0, v.eWe});
        checkOutput("dest",     {27'd0, dest},    {27'd0, v.eDest});
        checkOutput("writeVal", writeVal,         v.eVal);
        checkOutput("force1",   {31'd0, force1},  {31'd0, v.eForce});
    endtask

    initial begin
        // req0 only, dest 3
        vecs.push_back(mk(1, 5'd3, 32'hCAFEF00D, 0, 5'd0, 32'h0,  1, 0,  1, 5'd3, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1,  0, 5'd3, 32'hCAFEF00D, 0));
        // both valid, req0 wins, req1 follows with no gap
        vecs.push_back(mk(1, 5'd5, 32'h11,       1, 5'd6, 32'h22, 1, 0,  1, 5'd5, 32'h11, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd6, 32'h22, 1, 1,  1, 5'd6, 32'h22, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1,  0, 5'd6, 32'h22, 0));
        // starvation: req1 refused for 4 cycles, then forced
        vecs.push_back(mk(1, 5'd8, 32'h80,       1, 5'd9, 32'h99, 1, 0,  1, 5'd8, 32'h80, 0));
        vecs.push_back(mk(1, 5'd8, 32'h81,       1, 5'd9, 32'h99, 1, 0,  1, 5'd8, 32'h81, 0));
        vecs.push_back(mk(1, 5'd8, 32'h82,       1, 5'd9, 32'h99, 1, 0,  1, 5'd8, 32'h82, 0));
        vecs.push_back(mk(1, 5'd8, 32'h83,       1, 5'd9, 32'h99, 1, 0,  1, 5'd8, 32'h83, 1));
        vecs.push_back(mk(1, 5'd8, 32'h84,       1, 5'd9, 32'h99, 0, 1,  1, 5'd9, 32'h99, 0));
        vecs.push_back(mk(1, 5'd8, 32'h84,       0, 5'd0, 32'h0,  1, 0,  1, 5'd8, 32'h84, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1,  0, 5'd8, 32'h84, 0));
        // register 0 from either side: bus updates, no write enable
        vecs.push_back(mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0,  1, 0,  0, 5'd0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h55, 1, 1,  0, 5'd0, 32'h55, 0));
        // same dest on both ports: req0 first, req1 last
        vecs.push_back(mk(1, 5'd7, 32'hAAAA,     1, 5'd7, 32'hBBBB, 1, 0, 1, 5'd7, 32'hAAAA, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd7, 32'hBBBB, 1, 1, 1, 5'd7, 32'hBBBB, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1,  0, 5'd7, 32'hBBBB, 0));
        // req1 blocked once then withdraws before getting through
        vecs.push_back(mk(1, 5'd1, 32'h1,        1, 5'd2, 32'h2,  1, 0,  1, 5'd1, 32'h1, 0));
        vecs.push_back(mk(1, 5'd1, 32'h3,        0, 5'd0, 32'h0,  1, 0,  1, 5'd1, 32'h3, 0));

        rst = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("writeEn",  {31'd0, writeEn}, 32'd0);
        checkOutput("dest",     {27'd0, dest},    32'd0);
        checkOutput("writeVal", writeVal,         32'd0);
        checkOutput("force1",   {31'd0, force1},  32'd0);
        checkOutput("req0_ready", {31'd0, req0_ready}, 32'd1);
        checkOutput("req1_ready", {31'd0, req1_ready}, 32'd1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            curTag = $sformatf("vec%0d", i);
            step(vecs[i]);
        end

        curTag = "regfile";
        checkOutput("reg7", regModel[7], 32'hBBBB);

        // Withdrawal during the forced cycle: nobody transfers.
        for (int i = 0; i < 4; i++) begin
            curTag = $sformatf("withdraw%0d", i);
            step(mk(1, 5'd11, 32'hA0 + i, 1, 5'd12, 32'hC12, 1, 0,
                    1, 5'd11, 32'hA0 + i, (i == 3)));
        end
        curTag = "withdraw4";
        step(mk(1, 5'd11, 32'hA4, 0, 5'd0, 32'h0, 0, 1, 0, 5'd11, 32'hA3, 0));
        curTag = "withdraw5";
        step(mk(1, 5'd11, 32'hA4, 0, 5'd0, 32'h0, 1, 0, 1, 5'd11, 32'hA4, 0));

        // Reach writeEn=1 and force1=1 together, then reset between edges.
        for (int i = 0; i < 4; i++) begin
            curTag = $sformatf("rstseq%0d", i);
            step(mk(1, 5'd13, 32'hB0 + i, 1, 5'd14, 32'hD14, 1, 0,
                    1, 5'd13, 32'hB0 + i, (i == 3)));
        end
        curTag = "asyncrst";
        #2 rst = 1'b1;
        #1;
        checkOutput("writeEn",  {31'd0, writeEn}, 32'd0);
        checkOutput("dest",     {27'd0, dest},    32'd0);
        checkOutput("writeVal", writeVal,         32'd0);
        checkOutput("force1",   {31'd0, force1},  32'd0);
        checkOutput("req0_ready", {31'd0, req0_ready}, 32'd1);
        checkOutput("req1_ready", {31'd0, req1_ready}, 32'd0);
        #2 rst = 1'b0;
        curTag = "postrst0";
        step(mk(0, 5'd0, 32'h0, 1, 5'd14, 32'hD14, 1, 1, 1, 5'd14, 32'hD14, 0));
        curTag = "postrst1";
        step(mk(1, 5'd15, 32'hE15, 1, 5'd16, 32'hF16, 1, 0, 1, 5'd15, 32'hE15, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
